twi_master: RTL
===============

Name: twi_master

Overview:
I2C bus initiator: the controller-side counterpart to our twi_slave2 responders. Performs single-byte register writes (START, addr+W, reg, data, STOP) and register reads (START, addr+W, reg, repeated START, addr+R, data, NACK, STOP) on an open-drain bus. Used for on-board bring-up and for polling peripherals such as the power chip. Open-drain pads stay in the top level via SB_IO; this block only emits "pull low" enables.

Parameters:
CLK_DIV, 40, clk cycles per quarter-bit (40 at clk_16mhz gives 100 kHz SCL); legal range 2..65535

Ports:
clk  in  1  system clock (clk_16mhz domain)
rst_n  in  1  asynchronous, active-low reset
start  in  1  request strobe; sampled only when busy=0
rw  in  1  0=register write, 1=register read
devAddr  in  7  7-bit target address
regAddr  in  8  register index
wrData  in  8  write payload (ignored when rw=1)
rdData  out  8  read result; valid when done=1 and rw was 1
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
nack  out  1  valid with done: 1 if any address/reg/data byte was not ACKed
sclIn  in  1  SCL pad input
sdaIn  in  1  SDA pad input
sclLow  out  1  1 = drive SCL low
sdaLow  out  1  1 = drive SDA low

Behaviour:
- Reset (async, active-low): sclLow=0, sdaLow=0, busy=0, done=0, nack=0, rdData=0, FSM=IDLE, tick counter=0. Asserting reset mid-transfer releases both lines in the same cycle; no STOP is generated.
- Tick generator: down-counter reloads CLK_DIV-1 and emits a 1-cycle tick at 0. Runs only when busy=1 and restarts at CLK_DIV-1 on start acceptance.
- start accepted when busy=0: devAddr/regAddr/wrData/rw are latched; busy=1 on the next cycle. start while busy is ignored.
- Every state is 4 quarter-phases (q0..q3) and advances one phase per tick.
  - START: q0 both released; q1..q3 sdaLow=1.
  - Bit (TX/RX/ACK): q0 sclLow=1, SDA set up (TX drives the bit MSB first; RX and ACK-receive release SDA); q1 hold; q2 release SCL; q3 SCL high.
  - Sampling: sdaIn is sampled on the first q3 tick.
  - RESTART: q0 sclLow=1, SDA released; q1 release SCL; q2 sdaLow=1; q3 hold.
  - STOP: q0 sclLow=1, sdaLow=1; q1 release SCL; q2 release SDA; q3 idle.
- Clock stretching: in q2 and STOP/RESTART q1 the phase does not advance while sclIn=0. The tick counter is held at CLK_DIV-1 and restarts once sclIn reads 1.
- FSM: IDLE → START → TX_ADDR_W(8) → ACK → TX_REG(8) → ACK, then:
  - rw=0: TX_DATA(8) → ACK → STOP.
  - rw=1: RESTART → TX_ADDR_R(8) → ACK → RX_DATA(8) → master NACK (SDA released) → STOP.
- Any received ACK bit =1 sets nack and jumps directly to STOP; the remaining bytes are skipped.
- Completion: on the last STOP tick, busy=0 and done=1 for one cycle. rdData updates on the same cycle, and only for a successful read.
- No-stretch timing, measured from the start-sampled edge to done:
  - write: 116·CLK_DIV+1 cycles
  - read: 156·CLK_DIV+1 cycles
  - address NACK: 44·CLK_DIV+1 cycles
- Multi-master arbitration is not supported. sdaIn mismatch while driving high is ignored.
- Widths: shift register 8 bits; bit counter 3 bits (wraps 7→0 into ACK); phase 2 bits.

Decomposition:
- Package twi_pkg:
  - FSM state enum (IDLE, START, TX, TX_ACK, RESTART, RX, RX_ACK, STOP) and byte-select enum (ADDR_W, REG, DATA, ADDR_R).
  - Phase constants Q0..Q3 and RW_WRITE=0 / RW_READ=1.
  - Shared with twi_slave2 benches.
- Sub-module twi_tick: CLK_DIV quarter-tick counter with enable and stretch-hold inputs. Reusable beside clkdiv.

Test Plan:
- Write devAddr=0x34, regAddr=0x01, wrData=0x7F, model slave ACKs all: SDA bytes on SCL rising are 0x68, 0x01, 0x7F. done at 116·CLK_DIV+1 cycles, nack=0.
- Read devAddr=0x33, regAddr=0x00, slave returns 0xA5: bytes 0x66, 0x00, repeated START, 0x67, then master NACK and STOP. rdData=0xA5, nack=0, done at 156·CLK_DIV+1.
- No device at 0x50: first ACK samples 1 → STOP immediately, done at 44·CLK_DIV+1, nack=1, rdData unchanged.
- Slave holds SCL low 100 cycles during bit 3 of the reg byte: done delayed by exactly 100 cycles, bytes intact.
- Assert rst_n=0 during TX_DATA: sclLow=0 and sdaLow=0 asynchronously, busy=0. After release a new write completes normally.
- Pulse start again 10 cycles after acceptance with different devAddr: ignored. Bus carries only the first transaction, exactly one done pulse.

Source files
------------

// File: rtl/twi_pkg.sv
// Shared encodings for the TWI (I2C) master: FSM states, byte selectors,
// quarter-phase constants and read/write direction values.
package twi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        TX,
        TX_ACK,
        RESTART,
        RX,
        RX_ACK,
        STOP
    } twi_state_e;

    typedef enum logic [1:0] {
        ADDR_W,
        REG,
        DATA,
        ADDR_R
    } twi_byte_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/twi_tick.sv
// Quarter-bit tick generator: down-counter emitting a one-cycle tick every
// CLK_DIV cycles while enabled; load and hold both park it at CLK_DIV-1.
module twi_tick #(
    parameter int unsigned CLK_DIV = 40
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_load,
    input  logic i_hold,
    output logic o_tick
);

    localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load || i_hold) begin
            r_cnt <= RELOAD;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - 16'd1;
        end
    end

    assign o_tick = i_en && !i_hold && (r_cnt == '0);

endmodule

// File: rtl/twi_master.sv
// I2C initiator for single-byte register writes and reads on an open-drain bus.
// Drives only pull-low enables; every FSM state spans four tick-paced quarter phases.
module twi_master #(
    parameter int unsigned CLK_DIV = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] devAddr,
    input  logic [7:0] regAddr,
    input  logic [7:0] wrData,
    output logic [7:0] rdData,
    output logic       busy,
    output logic       done,
    output logic       nack,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       sclLow,
    output logic       sdaLow
);
    import twi_pkg::*;

    twi_state_e r_state, w_state_nx;
    twi_byte_e  r_byte,  w_byte_nx;
    logic [1:0] r_phase, w_phase_nx;
    logic [2:0] r_bit,   w_bit_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic [7:0] r_rd,    w_rd_nx;
    logic       r_busy,  w_busy_nx;
    logic       r_done,  w_done_nx;
    logic       r_nack,  w_nack_nx;
    logic       r_rw;
    logic [6:0] r_dev;
    logic [7:0] r_reg;
    logic [7:0] r_wdat;
    logic       w_accept;
    logic       w_tick;
    logic       w_hold;

    assign w_accept = start && !r_busy;
    // A slave may stretch wherever the master has just released SCL.
    assign w_hold = !sclIn &&
                    ((r_phase == Q2 && r_state != IDLE) ||
                     (r_phase == Q1 && (r_state == STOP || r_state == RESTART)));

    twi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (r_busy),
        .i_load  (w_accept),
        .i_hold  (w_hold),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_byte  <= ADDR_W;
            r_phase <= Q0;
            r_bit   <= '0;
            r_shift <= '0;
            r_rd    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nack  <= 1'b0;
            r_rw    <= RW_WRITE;
            r_dev   <= '0;
            r_reg   <= '0;
            r_wdat  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_byte  <= w_byte_nx;
            r_phase <= w_phase_nx;
            r_bit   <= w_bit_nx;
            r_shift <= w_shift_nx;
            r_rd    <= w_rd_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_nack  <= w_nack_nx;
            if (w_accept) begin
                r_rw   <= rw;
                r_dev  <= devAddr;
                r_reg  <= regAddr;
                r_wdat <= wrData;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_byte_nx  = r_byte;
        w_phase_nx = r_phase;
        w_bit_nx   = r_bit;
        w_shift_nx = r_shift;
        w_rd_nx    = r_rd;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_nack_nx  = r_nack;
        if (w_accept) begin
            w_state_nx = START;
            w_phase_nx = Q0;
            w_busy_nx  = 1'b1;
            w_nack_nx  = 1'b0;
        end else if (w_tick) begin
            if (r_phase != Q3) begin
                w_phase_nx = r_phase + 2'd1;
            end else begin
                w_phase_nx = Q0;
                case (r_state)
                    START: begin
                        w_state_nx = TX;
                        w_byte_nx  = ADDR_W;
                        w_bit_nx   = '0;
                        w_shift_nx = {r_dev, RW_WRITE};
                    end
                    TX: begin
                        w_shift_nx = {r_shift[6:0], 1'b0};
                        w_bit_nx   = r_bit + 3'd1;
                        if (r_bit == 3'd7) w_state_nx = TX_ACK;
                    end
                    TX_ACK: begin
                        if (sdaIn) begin
                            w_nack_nx  = 1'b1;
                            w_state_nx = STOP;
                        end else begin
                            case (r_byte)
                                ADDR_W: begin
                                    w_state_nx = TX;
                                    w_byte_nx  = REG;
                                    w_shift_nx = r_reg;
                                end
                                REG: begin
                                    if (r_rw == RW_READ) begin
                                        w_state_nx = RESTART;
                                    end else begin
                                        w_state_nx = TX;
                                        w_byte_nx  = DATA;
                                        w_shift_nx = r_wdat;
                                    end
                                end
                                DATA:    w_state_nx = STOP;
                                default: w_state_nx = RX;
                            endcase
                        end
                    end
                    RESTART: begin
                        w_state_nx = TX;
                        w_byte_nx  = ADDR_R;
                        w_bit_nx   = '0;
                        w_shift_nx = {r_dev, RW_READ};
                    end
                    RX: begin
                        w_shift_nx = {r_shift[6:0], sdaIn};
                        w_bit_nx   = r_bit + 3'd1;
                        if (r_bit == 3'd7) w_state_nx = RX_ACK;
                    end
                    RX_ACK: w_state_nx = STOP;
                    STOP: begin
                        w_state_nx = IDLE;
                        w_busy_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                        if (r_rw == RW_READ && !r_nack) w_rd_nx = r_shift;
                    end
                    default: w_state_nx = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        sclLow = 1'b0;
        sdaLow = 1'b0;
        case (r_state)
            START: sdaLow = (r_phase != Q0);
            TX: begin
                sclLow = (r_phase == Q0) || (r_phase == Q1);
                sdaLow = !r_shift[7];
            end
            TX_ACK, RX, RX_ACK: sclLow = (r_phase == Q0) || (r_phase == Q1);
            RESTART: begin
                sclLow = (r_phase == Q0);
                sdaLow = (r_phase == Q2) || (r_phase == Q3);
            end
            STOP: begin
                sclLow = (r_phase == Q0);
                sdaLow = (r_phase == Q0) || (r_phase == Q1);
            end
            default: ;
        endcase
    end

    assign rdData = r_rd;
    assign busy   = r_busy;
    assign done   = r_done;
    assign nack   = r_nack;

endmodule
